// File: rtl/exp_job_sequencer.sv
// Host-side job sequencer for the e^x core: queues operands, issues one start
// per job, waits for done (with a watchdog) and returns the 2.16 result.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no job in flight; pops the FIFO head when one is queued
// START | acc_start is high for this single cycle
// WAIT  | watchdog running; captures on done or aborts on timeout
// OUT   | result held on the output stream until it is accepted
module exp_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  output logic        acc_start,
  output logic [15:0] acc_x,
  input  logic        acc_done,
  input  logic [1:0]  acc_int,
  input  logic [15:0] acc_frac,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_x,
  output logic [17:0] out_result,
  output logic        out_err,
  output logic        busy,
  output logic [7:0]  jobs_done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(TIMEOUT);
  // Watchdog is a down-counter: the load value marks the first WAIT cycle
  // (where a stale done is masked) and zero is the terminal count.
  localparam logic [CW-1:0] TMR_LOAD = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  state_t          state;
  logic [15:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [CW-1:0]   wait_tmr;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && !empty;
  assign busy     = (state != IDLE) || !empty;

  // Operand storage; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_x;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Job FSM with registered core and result-stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      acc_start  <= 1'b0;
      acc_x      <= '0;
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_result <= '0;
      out_err    <= 1'b0;
      jobs_done  <= '0;
      wait_tmr   <= '0;
    end else begin
      acc_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            acc_x     <= mem[rd_ptr];
            acc_start <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          wait_tmr <= TMR_LOAD;
          state    <= WAIT;
        end
        WAIT: begin
          if (acc_done && (wait_tmr != TMR_LOAD)) begin
            out_result <= {acc_int, acc_frac};
            out_x      <= acc_x;
            out_err    <= 1'b0;
            out_valid  <= 1'b1;
            jobs_done  <= jobs_done + 1'b1;
            state      <= OUT;
          end else if (wait_tmr == '0) begin
            out_result <= '0;
            out_x      <= acc_x;
            out_err    <= 1'b1;
            out_valid  <= 1'b1;
            jobs_done  <= jobs_done + 1'b1;
            state      <= OUT;
          end else begin
            wait_tmr <= wait_tmr - 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exp_job_sequencer.sv
// Bench for exp_job_sequencer: a behavioural core model plus a job-queue
// scoreboard that predicts start order, output timing, result and error.
module tb_exp_job_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int M_NORM  = 0;
  localparam int M_MASK  = 1;
  localparam int M_HANG  = 2;

  typedef struct {
    logic [15:0] x;
    int          mode;
    int          n;
  } job_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic        acc_start;
  logic [15:0] acc_x;
  logic        acc_done;
  logic [1:0]  acc_int;
  logic [15:0] acc_frac;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x;
  logic [17:0] out_result;
  logic        out_err;
  logic        busy;
  logic [7:0]  jobs_done;

  exp_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .acc_start(acc_start), .acc_x(acc_x), .acc_done(acc_done),
    .acc_int(acc_int), .acc_frac(acc_frac),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_result(out_result), .out_err(out_err),
    .busy(busy), .jobs_done(jobs_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  job_t        job_q[$];
  job_t        cur;
  bit          in_flight     = 0;
  int          start_cyc     = 0;
  int          exp_rise      = 0;
  logic [17:0] exp_res       = '0;
  logic        exp_err       = 1'b0;
  logic [7:0]  exp_jobs      = '0;
  int          n_starts      = 0;
  int          raw_starts    = 0;
  int          n_outs        = 0;
  int          last_hs       = 0;
  int          last_acc      = 0;
  bit          exact_restart = 0;
  bit          chk_first_lat = 0;
  bit          rand_ready    = 0;
  bit          prev_start    = 0;
  bit          prev_ov       = 0;
  logic [34:0] snap          = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference e^x core: exact values for the two documented operands,
  // a second-order series for everything else.
  function automatic logic [17:0] core_res(input logic [15:0] x);
    logic [31:0] sq;
    if (x == 16'h0000) return 18'h10000;
    if (x == 16'h8000) return 18'h1A612;
    sq = 32'(x) * 32'(x);
    return 18'h10000 + 18'(x) + 18'(sq >> 17);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Core model: drives done level and result according to the job mode.
  initial begin : core_model
    int k;
    bit d;
    logic [17:0] r;
    acc_done = 1'b0;
    acc_int  = '0;
    acc_frac = '0;
    forever begin
      @(posedge clk);
      #1;
      d = 1'b0;
      r = 18'($urandom);
      if (rst) begin
        d = 1'b0;
      end else if (in_flight) begin
        k = cyc - start_cyc;
        case (cur.mode)
          M_NORM:  d = (k >= cur.n);
          M_MASK:  d = (k <= 1) || (k >= 6);
          default: d = 1'b0;
        endcase
        if (d && !(cur.mode == M_MASK && k <= 1)) r = core_res(cur.x);
      end else begin
        d = (job_q.size() > 0) && (job_q[0].mode == M_MASK);
      end
      acc_done = d;
      {acc_int, acc_frac} = r;
    end
  end

  // Monitor/scoreboard sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_start = 0;
      prev_ov    = 0;
      continue;
    end
    if (acc_start) begin
      raw_starts++;
      chk("start_pulse_len", prev_start, 0);
      chk("start_while_out", out_valid, 0);
      chk("busy_in_job", busy, 1);
      if (job_q.size() == 0) begin
        chk("start_unexpected", 1, 0);
      end else begin
        cur = job_q.pop_front();
        chk("acc_x_order", acc_x, cur.x);
        in_flight = 1;
        start_cyc = cyc;
        n_starts++;
        case (cur.mode)
          M_NORM:  exp_rise = cyc + cur.n + 1;
          M_MASK:  exp_rise = cyc + 7;
          default: exp_rise = cyc + TIMEOUT + 1;
        endcase
        exp_err = (cur.mode == M_HANG);
        exp_res = exp_err ? 18'h0 : core_res(cur.x);
        if (exact_restart) begin
          chk("restart_latency", cyc, last_hs + 2);
          exact_restart = 0;
        end
        if (chk_first_lat) begin
          chk("start_latency", cyc, last_acc + 2);
          chk_first_lat = 0;
        end
      end
    end
    if (out_valid && !prev_ov) begin
      chk("out_in_flight", in_flight, 1);
      chk("out_latency", cyc, exp_rise);
      chk("out_x", out_x, cur.x);
      chk("out_result", out_result, exp_res);
      chk("out_err", out_err, exp_err);
      exp_jobs = exp_jobs + 8'd1;
      chk("jobs_done", jobs_done, exp_jobs);
      snap = {out_x, out_result, out_err};
    end else if (out_valid) begin
      chk("out_hold", {out_x, out_result, out_err}, snap);
    end
    if (out_valid && out_ready) begin
      last_hs   = cyc;
      n_outs++;
      in_flight = 0;
    end
    prev_start = acc_start;
    prev_ov    = out_valid;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  task automatic push_op(input logic [15:0] x, input int mode, input int n);
    int   k  = 0;
    bit   ok = 0;
    job_t j;
    in_valid = 1'b1;
    in_x     = x;
    while (!ok && k < 400) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        ok     = 1;
        j.x    = x;
        j.mode = mode;
        j.n    = n;
        job_q.push_back(j);
        last_acc = cyc;
      end else begin
        k++;
      end
    end
    if (!ok) chk("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_x     = 16'($urandom);
  endtask

  task automatic wait_outs(input int target);
    int k = 0;
    while (n_outs < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("outs_complete", n_outs, target);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    job_q.delete();
    in_flight     = 0;
    exp_jobs      = '0;
    exact_restart = 0;
    chk_first_lat = 0;
    @(negedge clk);
    chk("rst_in_ready_low", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_jobs_done", jobs_done, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    int s0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_x = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_acc_start", acc_start, 0);
    chk("reset_acc_x", acc_x, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_x", out_x, 0);
    chk("reset_out_result", out_result, 0);
    chk("reset_out_err", out_err, 0);
    chk("reset_busy", busy, 0);
    chk("reset_jobs_done", jobs_done, 0);
    chk("reset_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single job with documented start latency.
    out_ready = 1'b1;
    chk_first_lat = 1;
    push_op(16'h0000, M_NORM, 5);
    wait_outs(1);
    chk("single_starts", n_starts, 1);

    // Held result with queued burst, then FIFO full and refill after pop.
    out_ready = 1'b0;
    push_op(16'h1234, M_NORM, 3);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    fork
      begin
        push_op(16'h8000, M_NORM, 4);
        push_op(16'h4000, M_NORM, 2);
        push_op(16'h2000, M_NORM, 7);
        push_op(16'h1000, M_NORM, 3);
        @(negedge clk);
        chk("in_ready_full", in_ready, 0);
        @(posedge clk);
        #1;
        push_op(16'hFFFF, M_NORM, 5);
        chk("fifth_accept", last_acc, last_hs + 2);
      end
      begin
        repeat (10) @(posedge clk);
        #1;
        exact_restart = 1;
        out_ready = 1'b1;
      end
    join
    rand_ready = 1;
    wait_outs(7);
    rand_ready = 0;
    out_ready = 1'b1;
    chk("burst_starts", n_starts, 7);

    // Watchdog abort followed by a normal job.
    do_reset();
    push_op(16'hABCD, M_HANG, 0);
    push_op(16'h5555, M_NORM, 4);
    wait_outs(9);
    chk("timeout_jobs_done", jobs_done, 2);

    // Stale done masked on the first WAIT cycle.
    push_op(16'h3333, M_MASK, 0);
    wait_outs(10);

    // Randomized jobs with random backpressure.
    rand_ready = 1;
    for (int i = 0; i < 24; i++) begin
      int m;
      int r;
      r = $urandom_range(0, 9);
      m = (r < 7) ? M_NORM : ((r < 9) ? M_MASK : M_HANG);
      push_op(16'($urandom), m, $urandom_range(2, 12));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    wait_outs(34);
    rand_ready = 0;
    out_ready = 1'b1;

    // Reset mid-WAIT with two operands queued.
    push_op(16'h7777, M_HANG, 0);
    push_op(16'h1111, M_NORM, 3);
    push_op(16'h2222, M_NORM, 3);
    k = 0;
    while (!(in_flight && cyc >= start_cyc + 4) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("reached_wait", in_flight, 1);
    @(posedge clk);
    #1;
    do_reset();
    s0 = raw_starts;
    repeat (30) @(negedge clk);
    chk("no_start_after_rst", raw_starts, s0);
    chk("idle_after_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
